// File: rtl/counter_161_if.sv
// Control, data and status bundle for one counter_161 stage.
// The master drives load/enables/data; the counter (slave) returns Q and the carry.
interface counter_161_if #(
   parameter int WIDTH = 4
);
   logic             n_load;
   logic             enp;
   logic             ent;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             co;

   modport master (
      output n_load,
      output enp,
      output ent,
      output D,
      input  Q,
      input  co
   );

   modport slave (
      input  n_load,
      input  enp,
      input  ent,
      input  D,
      output Q,
      output co
   );
endinterface

// File: rtl/counter_161.sv
// 74HC161-style loadable binary counter: one dff per bit, with next-state
// logic feeding the D pins and a combinational cascade carry.

module dff (
   input  logic C,
   input  logic n_rst,
   input  logic d_i,
   output logic q_o
);
   logic q_q;

   always_ff @(posedge C or negedge n_rst) begin
      if (!n_rst) q_q <= 1'b0;
      else        q_q <= d_i;
   end

   assign q_o = q_q;
endmodule

module counter_161 #(
   parameter int WIDTH = 4
) (
   input  logic          C,
   input  logic          n_rst,
   counter_161_if.slave  bus
);
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Load beats counting; counting needs both enables.
   always_comb begin
      cnt_d = cnt_q;
      if (!bus.n_load)
         cnt_d = bus.D;
      else if (bus.enp && bus.ent)
         cnt_d = cnt_q + 1'b1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff u_dff (
         .C     (C),
         .n_rst (n_rst),
         .d_i   (cnt_d[i]),
         .q_o   (cnt_q[i])
      );
   end

   assign bus.Q  = cnt_q;
   assign bus.co = bus.ent & (&cnt_q);
endmodule

// File: tb/tb_counter_161.sv
// Directed bench for counter_161: 4-bit unit, an 8-bit cascade and a 1-bit unit.
module tb_counter_161;
   logic C;
   logic n_rst;
   logic rst_c;
   int   n_chk;
   int   n_fail;

   counter_161_if #(.WIDTH(4)) b4 ();
   counter_161_if #(.WIDTH(4)) lo ();
   counter_161_if #(.WIDTH(4)) hi ();
   counter_161_if #(.WIDTH(1)) b1 ();

   counter_161 #(.WIDTH(4)) u_dut4 (.C(C), .n_rst(n_rst), .bus(b4.slave));
   counter_161 #(.WIDTH(4)) u_lo   (.C(C), .n_rst(rst_c), .bus(lo.slave));
   counter_161 #(.WIDTH(4)) u_hi   (.C(C), .n_rst(rst_c), .bus(hi.slave));
   counter_161 #(.WIDTH(1)) u_dut1 (.C(C), .n_rst(rst_c), .bus(b1.slave));

   assign hi.ent = lo.co;

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      n_rst  = 1'b0;
      rst_c  = 1'b0;
      b4.n_load = 1'b1; b4.enp = 1'b1; b4.ent = 1'b1; b4.D = 4'h0;
      lo.n_load = 1'b1; lo.enp = 1'b1; lo.ent = 1'b1; lo.D = 4'h0;
      hi.n_load = 1'b1; hi.enp = 1'b1;                hi.D = 4'h0;
      b1.n_load = 1'b1; b1.enp = 1'b0; b1.ent = 1'b1; b1.D = 1'b0;

      #1;
      chk("reset_q", {4'h0, b4.Q}, 8'h00);
      chk("reset_co", {7'h0, b4.co}, 8'h00);
      #49;
      n_rst = 1'b1;

      // free count 1..15 then wrap; co only at 15
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("count_q", {4'h0, b4.Q}, 8'(i % 16));
         chk("count_co", {7'h0, b4.co}, (i % 16 == 15) ? 8'h01 : 8'h00);
      end

      tick(); tick(); tick();
      chk("pre_load_q", {4'h0, b4.Q}, 8'h03);
      b4.n_load = 1'b0; b4.D = 4'b1010;
      tick();
      b4.n_load = 1'b1;
      chk("load_prio", {4'h0, b4.Q}, 8'h0A);

      b4.n_load = 1'b0; b4.D = 4'h5;
      tick();
      b4.n_load = 1'b1; b4.enp = 1'b0; b4.ent = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("enp0_hold", {4'h0, b4.Q}, 8'h05);
      chk("enp0_co", {7'h0, b4.co}, 8'h00);
      b4.enp = 1'b1; b4.ent = 1'b0;
      tick(); tick(); tick();
      chk("ent0_hold", {4'h0, b4.Q}, 8'h05);

      b4.n_load = 1'b0; b4.D = 4'hF;
      tick();
      b4.n_load = 1'b1;
      chk("loadF_q", {4'h0, b4.Q}, 8'h0F);
      chk("loadF_ent0_co", {7'h0, b4.co}, 8'h00);
      b4.ent = 1'b1;
      #1;
      chk("ent_rise_co", {7'h0, b4.co}, 8'h01);
      tick();
      chk("wrap_q", {4'h0, b4.Q}, 8'h00);
      chk("wrap_co", {7'h0, b4.co}, 8'h00);

      // async reset while counting at 9
      b4.n_load = 1'b0; b4.D = 4'h8;
      tick();
      b4.n_load = 1'b1;
      tick();
      chk("at_nine", {4'h0, b4.Q}, 8'h09);
      #2;
      n_rst = 1'b0;
      #1;
      chk("async_rst_q", {4'h0, b4.Q}, 8'h00);
      chk("async_rst_co", {7'h0, b4.co}, 8'h00);
      b4.n_load = 1'b0; b4.D = 4'h7;
      tick(); tick(); tick();
      chk("rst_held_q", {4'h0, b4.Q}, 8'h00);
      n_rst = 1'b1; b4.n_load = 1'b1;
      tick();
      chk("release_q", {4'h0, b4.Q}, 8'h01);

      b4.n_load = 1'b0; b4.D = 4'hF; b4.enp = 1'b0;
      chk("pre_loadF_co", {7'h0, b4.co}, 8'h00);
      tick();
      b4.n_load = 1'b1;
      chk("loadF_ent1_co", {7'h0, b4.co}, 8'h01);

      // 8-bit cascade from reset
      #2;
      rst_c = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      chk("cas_16", {hi.Q, lo.Q}, 8'h10);
      for (int i = 16; i < 255; i++) tick();
      chk("cas_255", {hi.Q, lo.Q}, 8'hFF);
      chk("cas_255_co", {7'h0, hi.co}, 8'h01);
      tick();
      chk("cas_wrap", {hi.Q, lo.Q}, 8'h00);
      chk("cas_wrap_co", {7'h0, hi.co}, 8'h00);

      // 1-bit counter
      chk("w1_hold", {7'h0, b1.Q}, 8'h00);
      b1.enp = 1'b1;
      tick();
      chk("w1_q1", {7'h0, b1.Q}, 8'h01);
      chk("w1_co1", {7'h0, b1.co}, 8'h01);
      b1.ent = 1'b0;
      #1;
      chk("w1_co_ent0", {7'h0, b1.co}, 8'h00);
      b1.ent = 1'b1;
      tick();
      chk("w1_q0", {7'h0, b1.Q}, 8'h00);
      chk("w1_co0", {7'h0, b1.co}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/counter_161.md
# counter_161

Synchronous binary counter with parallel load and cascadable carry, functionally equivalent to a 74HC161. It is built directly on top of the single-bit `dff` stage: each state bit is one `dff` instance, and this block supplies the next-state logic that feeds their D inputs. Within the CPU it serves as the program counter and as general-purpose loadable registers. The load path takes a jump target, and `co` allows multiple counters to be chained into wider ones.

## Interface
- `WIDTH`, 4, number of counter bits (≥1); one `dff` per bit
- `C`  in  1  clock, rising-edge active
- `n_rst`  in  1  reset, asynchronous, active-low; forces the counter to zero immediately, independent of `C`
- `n_load`  in  1  synchronous parallel load, active-low
- `enp`  in  1  count enable P (count-only gate)
- `ent`  in  1  count enable T (gates counting and `co`)
- `D`  in  WIDTH  parallel load data
- `Q`  out  WIDTH  counter state (the `dff` outputs)
- `co`  out  1  ripple carry out = `ent` & (`Q` == all ones)

## Operation
- Next-state priority, evaluated at each rising `C` while `n_rst`=1:
  1. `n_load`=0: `Q` ← `D`. Overrides `enp` and `ent`.
  2. `n_load`=1, `enp`=1, `ent`=1: `Q` ← `Q`+1 mod 2^WIDTH.
  3. Otherwise: `Q` holds.
- Arithmetic: unsigned. Increment wraps from 2^WIDTH−1 to 0 with no sticky overflow. The carry is visible only through `co`.
- `co` is combinational from `ent` and `Q` and is not registered. `enp` does not affect `co`.
- Structure: the next-state mux drives the `dff` D pins. `n_rst` fans out unchanged to every `dff` `n_rst`, and `C` fans out to every `dff` `C`. There is no other storage.
- Reset:
  - `n_rst`=0 forces `Q`=0 asynchronously, so `co`=0.
  - While `n_rst`=0, clock edges, loads and enables are ignored.
  - Reset asserted mid-count discards the count. There is no partial update.
- Release: the first rising `C` with `n_rst`=1 applies the normal priority. `n_rst` rising on the same edge as `C` counts as reset still held. Inputs must not rely on that edge.
- Cascading: counter k+1 takes `ent` = `co` of counter k and shares `enp`, `C`, `n_rst` and `n_load`.

## Timing
- Load and count latency: 1 cycle. `Q` updates after the rising `C` on which the control was sampled.
- `co` follows `Q` and `ent` combinationally in the same cycle.
- Setup and hold of `D`, `n_load`, `enp` and `ent` are relative to the rising `C` only. Changes between edges have no effect.
- Reset-to-`Q` latency: combinational through the `dff` async clear, with no clock needed.
- Reset values: `Q`=0. `co`=0 whatever the level of `ent`, because `Q` is not all ones.
- Simultaneous cases:
  - Load and count on the same edge: load wins.
  - Load of all ones with `ent`=1: `co`=1 from the following cycle.
  - `Q`=all ones with counting enabled: next `Q`=0, and `co` drops in that same cycle.

## Test plan
- Reset then count: `n_rst`=0 for 50 ns, then 1, with `enp`=`ent`=1 and `n_load`=1.
  - `Q` = 0,1,2,…,15,0 on successive edges.
  - `co`=1 only while `Q`=15.
- Load priority: with `Q`=3, apply `n_load`=0, `D`=4'b1010, `enp`=`ent`=1 for one edge. Then `Q`=10, not 4.
- Enable gating, starting from `Q`=5:
  - `enp`=0, `ent`=1: `Q` stays 5 over 10 edges; `co`=0.
  - `ent`=0: `Q` stays 5.
  - Load `D`=15 with `ent`=0: `co`=0. Raising `ent` to 1 then gives `co`=1 without a clock edge.
- Asynchronous reset mid-operation: counting at `Q`=9, drop `n_rst` between clock edges.
  - `Q`=0 and `co`=0 before the next edge.
  - Hold `n_rst` low for 3 edges with `n_load`=0 and `D`=7: `Q` stays 0.
- Cascade: two instances chained as an 8-bit counter, `enp`=1, first-stage `ent`=1.
  - After 255 edges from reset: {hi,lo} = 8'hFF and hi `co`=1.
  - On the next edge: 8'h00 and hi `co`=0.
- WIDTH=1 instance: `Q` toggles 0,1,0 when enabled, and `co`=`ent` while `Q`=1.
